sdram_rd_engine: RTL
====================

# sdram_rd_engine

Host-side read initiator for the SDRAM controller's read port. It receives a start command with a base word address and length, and issues one single-word read request per accepted cycle. Returned words are collected into an internal FIFO and streamed in order to the downstream consumer (USB/readback path) with ready/valid backpressure. A credit scheme guarantees the returned data, which cannot be stalled, never overflows the FIFO.

## Interface
- DEPTH, 16: internal FIFO depth in words; power of two, ≥4; also the cap on words outstanding plus buffered.
- AW, 32: address width.
- LW, 32: length field width.

- sdram_clk  in  1  clock for all logic.
- sdram_rst_  in  1  reset, asynchronous assert, active-low.
- sd_init_done  in  1  SDRAM initialised; no request is issued while low.
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy.
- base_addr  in  AW  first word address, sampled on start.
- length  in  LW  word count, sampled on start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last word leaves the output stream.
- err  out  1  sticky protocol error, cleared only by reset.
- rd_req  out  1  read request to the controller.
- rd_addr  out  AW  request address.
- rd_valid  in  1  request accepted this cycle (rd_req & controller ready).
- rd_rdy  in  1  returned-data strobe, one word per cycle, in request order.
- rd_data  in  16  returned data, qualified by rd_rdy.
- dout  out  16  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts dout.

## Operation
- States: IDLE, WAIT_INIT, ISSUE, DRAIN, DONE.
- IDLE: start with length≠0 latches addr←base_addr and remaining←length. Next state is WAIT_INIT if sd_init_done=0, otherwise ISSUE. start with length=0 goes to DONE directly and issues no request.
- WAIT_INIT → ISSUE when sd_init_done=1.
- ISSUE: rd_req = (outstanding + fifo_count < DEPTH); this is a combinational decode of registers only. rd_addr = addr.
- On rd_valid: addr←addr+1, which wraps modulo 2^AW. remaining←remaining−1 and outstanding←outstanding+1. When remaining reaches 0, go to DRAIN.
- rd_rdy: the word is written to the FIFO and outstanding←outstanding−1.
- If rd_valid and rd_rdy occur in the same cycle, outstanding is unchanged.
- DRAIN → DONE when outstanding=0 and the FIFO is empty and no word is being accepted.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- rd_rdy with outstanding=0, or a FIFO write when the FIFO is full: the word is dropped and err←1. State is unaffected.
- Output: dout/dout_valid come from the FIFO head; a pop occurs on dout_valid & dout_ready.
- Counters: outstanding and fifo_count are each log2(DEPTH)+1 bits wide.

## Timing
- Reset values: busy=0, done=0, err=0, rd_req=0, rd_addr=0, dout_valid=0, dout=0; state=IDLE, all counters 0.
- Reset asserted mid-transfer: everything returns to the reset values immediately. No done pulse is produced.
- The first rd_req is high in the cycle after start when sd_init_done=1.
- Peak issue rate is 1 request/cycle while credit allows.
- FIFO is first-word-fall-through. A word written on rd_rdy in cycle N is visible on dout with dout_valid=1 in cycle N+1.
- The last pop in cycle N gives done=1 in cycle N+1 at the earliest, when the DRAIN exit is registered, and busy=0 in cycle N+2.
- rd_req may drop in any cycle for lack of credit. rd_addr holds until rd_valid.

## Structure
- Shared package: state enum encoding, DEPTH default, and the credit-counter width function (clog2(DEPTH)+1).
- Sub-module sdram_rd_fifo: synchronous FWFT FIFO of DEPTH×16 with push, pop, count, full and empty. Uses the same async active-low reset.
- Top level holds the FSM, address/remaining/outstanding counters, and the err logic.

## Test plan
- Basic read: base=0x100, len=4. Controller model returns addr[15:0] as data with 3-cycle latency and dout_ready=1. Expect dout 0x0100..0x0103 in order, one done pulse, and busy low 2 cycles after the last pop.
- Backpressure: len=40, DEPTH=16, dout_ready=0 for 200 cycles. Expect exactly 16 requests accepted, then rd_req=0. After release, all 40 words arrive in order with err=0.
- Wrap and init gating: sd_init_done=0 at start with base=0xFFFFFFFE, len=4. Expect no rd_req until init rises, then addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Zero length / start while busy: len=0 gives done 1 cycle later with no rd_req. A second start during a len=8 transfer is ignored, giving exactly 8 words.
- Simultaneous events and error: rd_valid and rd_rdy in the same cycle leave the outstanding count correct. An injected stray rd_rdy in IDLE sets err=1 and the word is not output.
- Reset mid-op: assert sdram_rst_=0 during ISSUE. All outputs go to their reset values immediately, and a new start after release behaves like the basic read case.

Source files
------------

// File: rtl/sdram_rd_engine_pkg.sv
// Shared definitions for the SDRAM read engine: FSM encoding, default
// FIFO depth and the width rule for the credit counters.
package sdram_rd_engine_pkg;

   localparam int DEPTH_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   // Counters must hold 0..depth inclusive, hence one bit above log2.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// First-word-fall-through FIFO, DEPTH x 16. A word pushed in cycle N is
// presented on dout_o in cycle N+1. Push while full and pop while empty
// are ignored; the caller is responsible for flagging those cases.
module sdram_rd_fifo
   import sdram_rd_engine_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic [15:0]             din_i,
   input  logic                    pop_i,
   output logic [15:0]             dout_o,
   output logic [cnt_w(DEPTH)-1:0] count_o,
   output logic                    full_o,
   output logic                    empty_o
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = $clog2(DEPTH);

   logic [15:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = empty_o ? 16'h0000 : mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are only meaningful under the occupancy count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/sdram_rd_engine.sv
// Read initiator for the SDRAM controller read port. Issues one read per
// accepted cycle from base_addr for length words, buffers returned words in
// a FWFT FIFO and streams them out with ready/valid. Requests are only made
// while outstanding + buffered < DEPTH, so returned data (which cannot be
// stalled) always has a FIFO slot.
module sdram_rd_engine
   import sdram_rd_engine_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 32,
   parameter int LW    = 32
) (
   input  logic          sdram_clk,
   input  logic          sdram_rst_,
   input  logic          sd_init_done,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] length,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   input  logic          rd_valid,
   input  logic          rd_rdy,
   input  logic [15:0]   rd_data,
   output logic [15:0]   dout,
   output logic          dout_valid,
   input  logic          dout_ready
);

   localparam int CW = cnt_w(DEPTH);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [CW-1:0] outst_q, outst_d;
   logic          err_q, err_d;

   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic [15:0]   fifo_dout;
   logic [CW:0]   credit_sum;
   logic          accept, ret_ok, push, pop, stray, fifo_drained;

   // Credit covers words in flight plus words already buffered.
   assign credit_sum   = {1'b0, outst_q} + {1'b0, fifo_count};
   assign rd_req       = (state_q == ST_ISSUE) && (credit_sum < (CW+1)'(DEPTH));
   assign accept       = rd_req & rd_valid;
   assign ret_ok       = rd_rdy & (outst_q != '0);
   assign push         = ret_ok & ~fifo_full;
   assign stray        = rd_rdy & ((outst_q == '0) | fifo_full);
   assign dout_valid   = ~fifo_empty;
   assign pop          = dout_valid & dout_ready;
   // Empty now, or the last buffered word leaves this cycle; lets done follow
   // the final pop by exactly one cycle.
   assign fifo_drained = fifo_empty | (pop && (fifo_count == CW'(1)));

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign err     = err_q;
   assign rd_addr = addr_q;
   assign dout    = fifo_dout;

   sdram_rd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (sdram_clk),
      .rst_n   (sdram_rst_),
      .push_i  (push),
      .din_i   (rd_data),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Transfer FSM, address/remaining/outstanding counters and sticky error.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      outst_d = outst_q;
      err_d   = err_q | stray;

      // A request accepted and a word returned together cancel out.
      case ({accept, ret_ok})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_d  = base_addr;
                  rem_d   = length;
                  state_d = sd_init_done ? ST_ISSUE : ST_WAIT_INIT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_WAIT_INIT: begin
            if (sd_init_done) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (accept) begin
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == LW'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((outst_q == '0) && fifo_drained && !push) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers with asynchronous active-low reset.
   always_ff @(posedge sdram_clk or negedge sdram_rst_) begin
      if (!sdram_rst_) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

endmodule
